// File: rtl/polyphase_decim_pkg.sv
// Shared types and arithmetic helpers for the polyphase decimating FIR.
package polyphase_decim_pkg;

    typedef enum logic [1:0] {IDLE, MAC, SUM, OUT} state_e;

    // Helpers work at a fixed wide width; callers sign-extend in and truncate out.
    localparam int WIDE_W = 128;

    function automatic int acc_width(input int data_w, input int coef_w,
                                     input int num_ph, input int taps);
        return data_w + coef_w + $clog2(num_ph * taps);
    endfunction

    function automatic logic signed [WIDE_W-1:0] round_sat(
        input logic signed [WIDE_W-1:0] sum, input int shift, input int out_w);
        logic signed [WIDE_W-1:0] r;
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        r = sum;
        if (shift > 0)
            r = r + (WIDE_W'(1) << (shift - 1));
        r  = r >>> shift;
        hi = (WIDE_W'(1) << (out_w - 1)) - WIDE_W'(1);
        lo = ~hi;
        if (r > hi)
            r = hi;
        else if (r < lo)
            r = lo;
        return r;
    endfunction

    function automatic logic [WIDE_W-1:0] maj3(input logic [WIDE_W-1:0] a,
                                               input logic [WIDE_W-1:0] b,
                                               input logic [WIDE_W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/polyphase_decim_rx_branch.sv
// One polyphase branch: delay line, coefficient column and MAC accumulator.
// With POLY_TMR_EN the accumulator is triplicated, voted and scrubbed.
module poly_branch_mac
    import polyphase_decim_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int COEF_W = 16,
    parameter int TAPS   = 16,
    parameter int ACC_W  = 55,
    parameter int TW     = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     shift_i,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic                     coef_we_i,
    input  logic [TW-1:0]            coef_tap_i,
    input  logic signed [COEF_W-1:0] coef_i,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic [TW-1:0]            tap_i,
    output logic signed [ACC_W-1:0]  acc_o
`ifdef POLY_TMR_EN
    , output logic                   err_o
`endif
);

    localparam int PW = DATA_W + COEF_W;

    logic signed [DATA_W-1:0] x_q [TAPS];
    logic signed [COEF_W-1:0] h_q [TAPS];
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
        end else if (shift_i) begin
            x_q[0] <= x_i;
            for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
        end
    end

    // Coefficient storage survives reset so a reload is not needed after rst.
    always_ff @(posedge clk) begin
        if (coef_we_i) h_q[coef_tap_i] <= coef_i;
    end

    assign prod     = x_q[tap_i] * h_q[tap_i];
    assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

`ifdef POLY_TMR_EN
    logic [ACC_W-1:0] acc_q [3];
    logic signed [ACC_W-1:0] acc_v;

    assign acc_v = ACC_W'(maj3(WIDE_W'(acc_q[0]), WIDE_W'(acc_q[1]), WIDE_W'(acc_q[2])));
    assign acc_o = acc_v;
    assign err_o = (acc_q[0] != acc_q[1]) || (acc_q[0] != acc_q[2]);

    always_comb begin
        acc_d = acc_v;
        if (clr_i)
            acc_d = '0;
        else if (en_i)
            acc_d = acc_v + prod_ext;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) acc_q[i] <= rst ? '0 : acc_d;
    end
`else
    logic signed [ACC_W-1:0] acc_q;

    assign acc_o = acc_q;

    always_comb begin
        acc_d = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (en_i)
            acc_d = acc_q + prod_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end
`endif

endmodule

// File: rtl/polyphase_decim_rx.sv
// Polyphase decimating FIR: NUM_PH parallel branch MACs, adder tree, round/saturate.
// Define POLY_TMR_EN to triplicate accumulators and the output register with voting.
module polyphase_decim_rx
    import polyphase_decim_pkg::*;
#(
    parameter int NUM_PH    = 8,
    parameter int TAPS      = 16,
    parameter int DATA_W    = 32,
    parameter int COEF_W    = 16,
    parameter int OUT_W     = 32,
    parameter int OUT_SHIFT = 15
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PH*DATA_W-1:0]         s_tdata,
    input  logic                             s_tvalid,
    output logic                             s_tready,
    output logic signed [OUT_W-1:0]          m_tdata,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    input  logic                             coef_we,
    input  logic [$clog2(NUM_PH*TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]         coef_wdata,
    output logic                             busy,
    output logic                             tmr_err
);

    localparam int ACC_W = acc_width(DATA_W, COEF_W, NUM_PH, TAPS);
    localparam int TW    = $clog2(TAPS);
    localparam logic [TW-1:0] T_LAST = TW'(TAPS - 1);

    state_e                  state_q, state_d;
    logic [TW-1:0]           t_q, t_d;
    logic signed [OUT_W-1:0] m_tdata_d;
    logic                    accept, shift, clr, en, coef_ok;
    logic [TW-1:0]           coef_tap;
    logic [NUM_PH-1:0]       coef_sel;
    logic signed [ACC_W-1:0] acc [NUM_PH];
    logic signed [ACC_W-1:0] sum;

    assign s_tready = (state_q == IDLE) && !rst;
    assign accept   = s_tvalid && s_tready;
    assign busy     = (state_q != IDLE);
    assign m_tvalid = (state_q == OUT);

    // Writes land only while idle; the MAC starts a cycle after accept, so a
    // write coinciding with accept is already visible to that beat.
    always_comb begin
        coef_ok  = coef_we && !busy && (32'(coef_addr) < NUM_PH * TAPS);
        coef_tap = TW'(32'(coef_addr) % TAPS);
        for (int p = 0; p < NUM_PH; p++)
            coef_sel[p] = coef_ok && ((32'(coef_addr) / TAPS) == 32'(p));
    end

`ifdef POLY_TMR_EN
    logic [NUM_PH-1:0] br_err;
`endif

    for (genvar p = 0; p < NUM_PH; p++) begin : g_br
        poly_branch_mac #(
            .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ACC_W(ACC_W), .TW(TW)
        ) u_br (
            .clk       (clk),
            .rst       (rst),
            .shift_i   (shift),
            .x_i       (s_tdata[p*DATA_W +: DATA_W]),
            .coef_we_i (coef_sel[p]),
            .coef_tap_i(coef_tap),
            .coef_i    (coef_wdata),
            .clr_i     (clr),
            .en_i      (en),
            .tap_i     (t_q),
            .acc_o     (acc[p])
`ifdef POLY_TMR_EN
            , .err_o   (br_err[p])
`endif
        );
    end

    always_comb begin
        sum = '0;
        for (int p = 0; p < NUM_PH; p++) sum = sum + acc[p];
    end

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        m_tdata_d = m_tdata;
        shift     = 1'b0;
        clr       = 1'b0;
        en        = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                shift   = 1'b1;
                clr     = 1'b1;
                t_d     = '0;
                state_d = MAC;
            end
            MAC: begin
                en  = 1'b1;
                t_d = t_q + TW'(1);
                if (t_q == T_LAST) state_d = SUM;
            end
            SUM: begin
                m_tdata_d = OUT_W'(round_sat({{(WIDE_W-ACC_W){sum[ACC_W-1]}}, sum},
                                             OUT_SHIFT, OUT_W));
                state_d   = OUT;
            end
            OUT: if (m_tready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

`ifdef POLY_TMR_EN
    logic [OUT_W-1:0] out_q [3];
    logic             tmr_err_q;

    assign m_tdata = OUT_W'(maj3(WIDE_W'(out_q[0]), WIDE_W'(out_q[1]), WIDE_W'(out_q[2])));
    assign tmr_err = tmr_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) out_q[i] <= '0;
            tmr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) out_q[i] <= m_tdata_d;
            tmr_err_q <= tmr_err_q || (|br_err) ||
                         (out_q[0] != out_q[1]) || (out_q[0] != out_q[2]);
        end
    end
`else
    logic signed [OUT_W-1:0] m_tdata_q;

    assign m_tdata = m_tdata_q;
    assign tmr_err = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) m_tdata_q <= '0;
        else     m_tdata_q <= m_tdata_d;
    end
`endif

endmodule

// File: tb/tb_polyphase_decim_rx.sv
// Directed bench for polyphase_decim_rx: two instances (OUT_SHIFT 0 and 15) share all inputs.
module tb_polyphase_decim_rx;

    localparam int NP = 8;
    localparam int NT = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP*32-1:0] s_tdata = '0;
    logic            s_tvalid = 1'b0;
    logic            m_tready = 1'b1;
    logic            coef_we = 1'b0;
    logic [6:0]      coef_addr = '0;
    logic [15:0]     coef_wdata = '0;

    logic            s_tready0, m_tvalid0, busy0, tmr_err0;
    logic            s_tready1, m_tvalid1, busy1, tmr_err1;
    logic [31:0]     m_tdata0, m_tdata1;

    polyphase_decim_rx #(.NUM_PH(NP), .TAPS(NT), .DATA_W(32), .COEF_W(16),
                         .OUT_W(32), .OUT_SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready0),
        .m_tdata(m_tdata0), .m_tvalid(m_tvalid0), .m_tready(m_tready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .busy(busy0), .tmr_err(tmr_err0));

    polyphase_decim_rx #(.NUM_PH(NP), .TAPS(NT), .DATA_W(32), .COEF_W(16),
                         .OUT_W(32), .OUT_SHIFT(15)) dut1 (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready1),
        .m_tdata(m_tdata1), .m_tvalid(m_tvalid1), .m_tready(m_tready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .busy(busy1), .tmr_err(tmr_err1));

    always #5 clk = ~clk;

    typedef struct {
        bit          rst_b;
        int          cset;
        logic [31:0] fill;
        int          sp_ph;
        logic [31:0] sp_val;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cur_cset = -1;

    function automatic vec_t mk(bit r, int cs, logic [31:0] f, int ph, logic [31:0] v,
                                logic [31:0] e0, logic [31:0] e1);
        vec_t x;
        x.rst_b = r; x.cset = cs; x.fill = f; x.sp_ph = ph; x.sp_val = v;
        x.exp0 = e0; x.exp1 = e1;
        return x;
    endfunction

    function automatic logic [NP*32-1:0] pack(logic [31:0] f, int ph, logic [31:0] v);
        logic [NP*32-1:0] d;
        for (int p = 0; p < NP; p++) d[p*32 +: 32] = (p == ph) ? v : f;
        return d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    // cset 0: h[p][t] = p*16+t (equals the address); 1: all ones; 2: all 32767.
    task automatic load_coefs(input int cs);
        for (int a = 0; a < NP*NT; a++) begin
            @(negedge clk);
            coef_we    = 1'b1;
            coef_addr  = 7'(a);
            coef_wdata = (cs == 0) ? 16'(a) : (cs == 1) ? 16'd1 : 16'h7FFF;
        end
        @(negedge clk); coef_we = 1'b0;
        cur_cset = cs;
    endtask

    // we_mode 1: write h[0][0]=100 while busy; 2: write h[0][0]=5 in the accept cycle.
    task automatic do_beat(input logic [NP*32-1:0] d, input int we_mode,
                           output logic [31:0] y0, output logic [31:0] y1,
                           output int lat, output bit ok);
        @(negedge clk);
        s_tdata = d; s_tvalid = 1'b1;
        if (we_mode == 2) begin coef_we = 1'b1; coef_addr = '0; coef_wdata = 16'd5; end
        @(posedge clk);
        @(negedge clk);
        s_tvalid = 1'b0; coef_we = 1'b0;
        if (we_mode == 1) begin coef_we = 1'b1; coef_addr = '0; coef_wdata = 16'd100; end
        lat = 0; ok = 1'b0;
        while (lat < 100) begin
            if (m_tvalid0) begin ok = 1'b1; break; end
            @(negedge clk);
            coef_we = 1'b0;
            lat++;
        end
        y0 = m_tdata0; y1 = m_tdata1;
    endtask

    initial begin
        logic [31:0] y0, y1;
        int lat, cnt;
        bit ok;

        for (int k = 0; k < 16; k++)
            vecs.push_back(mk(k == 0, 0, 0, 3, (k == 0) ? 32'd1 : 32'd0, 32'(48 + k), 0));
        vecs.push_back(mk(1, 1, 1000, 0, 1000, 8000, 0));
        vecs.push_back(mk(0, 1, 1000, 0, 1000, 16000, 0));
        vecs.push_back(mk(0, 1, 1000, 0, 1000, 24000, 1));
        vecs.push_back(mk(0, 1, 1000, 0, 1000, 32000, 1));
        vecs.push_back(mk(0, 1, 1000, 0, 1000, 40000, 1));
        vecs.push_back(mk(0, 1, 1000, 0, 1000, 48000, 1));
        vecs.push_back(mk(0, 1, 1000, 0, 1000, 56000, 2));
        vecs.push_back(mk(0, 1, 1000, 0, 1000, 64000, 2));
        vecs.push_back(mk(0, 1, 1000, 0, 1000, 72000, 2));
        vecs.push_back(mk(0, 1, 1000, 0, 1000, 80000, 2));
        vecs.push_back(mk(0, 1, 1000, 0, 1000, 88000, 3));
        vecs.push_back(mk(0, 1, 1000, 0, 1000, 96000, 3));
        vecs.push_back(mk(0, 1, 1000, 0, 1000, 104000, 3));
        vecs.push_back(mk(0, 1, 1000, 0, 1000, 112000, 3));
        vecs.push_back(mk(0, 1, 1000, 0, 1000, 120000, 4));
        vecs.push_back(mk(0, 1, 1000, 0, 1000, 128000, 4));
        vecs.push_back(mk(0, 1, 1000, 0, 1000, 128000, 4));
        vecs.push_back(mk(0, 1, 1000, 0, 1000, 128000, 4));
        vecs.push_back(mk(1, 1, 0, 0, 49152, 49152, 2));
        vecs.push_back(mk(1, 1, 0, 0, 49151, 49151, 1));
        vecs.push_back(mk(1, 1, 0, 0, -32'sd49152, -32'sd49152, -32'sd1));
        vecs.push_back(mk(1, 1, 0, 0, -32'sd49153, -32'sd49153, -32'sd2));
        vecs.push_back(mk(1, 2, 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF));
        vecs.push_back(mk(1, 2, 32'h80000000, 0, 32'h80000000, 32'h80000000, 32'h80000000));

        // Reset state, sampled while rst is still held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_tready", {31'd0, s_tready0}, 0);
        check("rst_m_tvalid", {31'd0, m_tvalid0}, 0);
        check("rst_m_tdata",  m_tdata0, 0);
        check("rst_busy",     {31'd0, busy0}, 0);
        check("rst_tmr_err",  {31'd0, tmr_err0}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_s_tready", {31'd0, s_tready0}, 1);

        foreach (vecs[i]) begin
            if (vecs[i].rst_b) do_reset();
            if (vecs[i].cset != cur_cset) load_coefs(vecs[i].cset);
            do_beat(pack(vecs[i].fill, vecs[i].sp_ph, vecs[i].sp_val), 0, y0, y1, lat, ok);
            check($sformatf("vld[%0d]", i), {31'd0, ok}, 1);
            check($sformatf("lat[%0d]", i), 32'(lat), 17);
            check($sformatf("y0[%0d]", i), y0, vecs[i].exp0);
            check($sformatf("y1[%0d]", i), y1, vecs[i].exp1);
        end

        // Backpressure: output held stable, input side closed.
        load_coefs(1);
        do_reset();
        m_tready = 1'b0;
        do_beat(pack(5, 0, 5), 0, y0, y1, lat, ok);
        check("bp_y0", y0, 40);
        cnt = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (m_tdata0 !== 32'd40 || s_tready0 !== 1'b0 || m_tvalid0 !== 1'b1) cnt++;
        end
        check("bp_hold_bad_cycles", 32'(cnt), 0);
        m_tready = 1'b1;
        @(negedge clk);
        check("bp_release_vld", {31'd0, m_tvalid0}, 0);
        check("bp_release_rdy", {31'd0, s_tready0}, 1);

        // A write while busy is dropped, now and later.
        do_reset();
        do_beat(pack(0, 0, 2), 1, y0, y1, lat, ok);
        check("we_busy_y0", y0, 2);
        do_reset();
        do_beat(pack(0, 0, 3), 0, y0, y1, lat, ok);
        check("we_busy_later_y0", y0, 3);

        // A write in the accept cycle applies to that beat.
        do_reset();
        do_beat(pack(0, 0, 3), 2, y0, y1, lat, ok);
        check("we_accept_y0", y0, 15);

        // Reset mid-MAC: no output, and history is cleared.
        load_coefs(1);
        do_reset();
        @(negedge clk);
        s_tdata = pack(7, 0, 7); s_tvalid = 1'b1;
        @(posedge clk);
        @(negedge clk); s_tvalid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (m_tvalid0 === 1'b1) cnt++;
        end
        check("abort_no_vld", 32'(cnt), 0);
        do_beat(pack(0, 0, 3), 0, y0, y1, lat, ok);
        check("abort_next_vld", {31'd0, ok}, 1);
        check("abort_next_y0", y0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
